// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, IR and next-PC selection
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                beq,
    input  logic                bne,
    input  logic                jump,
    input  logic                zero,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic [5:0]          funct,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic [15:0]         retire_count
);
    localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic [31:0] next_pc;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        taken;
    logic        load_ir;
    logic        retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= PC_INIT;
            ir           <= 32'h0;
            retire_count <= 16'h0;
        end else begin
            state <= state_next;
            if (load_ir) begin
                ir <= imem.imem_rdata;
            end
            if (retire) begin
                pc           <= next_pc;
                retire_count <= retire_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        load_ir       = 1'b0;
        retire        = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    load_ir    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Branch/jump flags only matter through next_pc, which is consumed solely on retire.
    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    assign taken         = (beq & zero) | (bne & ~zero);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

    assign imem.imem_addr = pc;
    assign instr          = ir;
    assign opcode         = ir[31:26];
    assign funct          = ir[5:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, beq, bne, jump, zero;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic        instr_valid;
    logic [15:0] retire_count;

    logic [31:0] w_instr, w_pc, w_pc4;
    logic [5:0]  w_opcode, w_funct;
    logic        w_valid;
    logic [15:0] w_cnt;
    logic [31:0] j_instr, j_pc, j_pc4;
    logic [5:0]  j_opcode, j_funct;
    logic        j_valid;
    logic [15:0] j_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_cnt;

    fetch_unit_if bus ();
    fetch_unit_if w_bus ();
    fetch_unit_if j_bus ();

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem(bus.master),
        .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
        .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .retire_count(retire_count)
    );

    // Free-running instance for the top-of-address-space wrap.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .imem(w_bus.master),
        .stall(1'b0), .beq(1'b0), .bne(1'b0), .jump(1'b0), .zero(1'b0),
        .instr(w_instr), .opcode(w_opcode), .funct(w_funct), .instr_valid(w_valid),
        .pc(w_pc), .pc_plus4(w_pc4), .retire_count(w_cnt)
    );

    // Free-running instance for jump-over-branch priority; low PC bits must be masked.
    fetch_unit #(.RESET_PC(32'h4000_0013)) dut_j (
        .clk(clk), .reset(reset), .imem(j_bus.master),
        .stall(1'b0), .beq(1'b1), .bne(1'b0), .jump(1'b1), .zero(1'b1),
        .instr(j_instr), .opcode(j_opcode), .funct(j_funct), .instr_valid(j_valid),
        .pc(j_pc), .pc_plus4(j_pc4), .retire_count(j_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b_eq, input logic b_ne,
                                               input logic j, input logic z);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = $signed(w[15:0]);
        off = off * 4;
        if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if ((b_eq && z) || (b_ne && !z)) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic randomize_ignored();
        stall = 1'($urandom);
        beq   = 1'($urandom);
        bne   = 1'($urandom);
        jump  = 1'($urandom);
        zero  = 1'($urandom);
    endtask

    task automatic fetch_chk(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
        chk({tag, "_addr"}, bus.imem_addr, m_pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_ir"}, instr, m_ir);
    endtask

    task automatic hold_chk(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_instr"}, instr, m_ir);
        chk({tag, "_opcode"}, 32'(opcode), 32'(m_ir >> 26));
        chk({tag, "_funct"}, 32'(funct), m_ir & 32'h3F);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, "_cnt"}, 32'(retire_count), 32'(m_cnt));
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after retire.
    task automatic do_instr(input int waits, input int stalls, input logic [31:0] word,
                            input logic b_eq, input logic b_ne, input logic j, input logic z);
        logic [31:0] npc;
        for (int i = 0; i < waits; i++) begin
            fetch_chk("wait");
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            randomize_ignored();
            @(negedge clk);
        end
        fetch_chk("fetch");
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        randomize_ignored();
        @(negedge clk);
        m_ir = word;
        for (int i = 0; i < stalls; i++) begin
            hold_chk("stall");
            randomize_ignored();
            stall          = 1'b1;
            bus.imem_ready = 1'($urandom);
            bus.imem_rdata = $urandom;
            @(negedge clk);
        end
        hold_chk("retire");
        stall          = 1'b0;
        beq            = b_eq;
        bne            = b_ne;
        jump           = j;
        zero           = z;
        bus.imem_ready = 1'($urandom);
        bus.imem_rdata = $urandom;
        npc = model_next(m_pc, m_ir, b_eq, b_ne, j, z);
        @(negedge clk);
        m_pc  = npc;
        m_cnt = m_cnt + 16'd1;
        bus.imem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
        bus.imem_ready   = 1'b0; bus.imem_rdata   = 32'h0;
        w_bus.imem_ready = 1'b1; w_bus.imem_rdata = 32'h0;
        j_bus.imem_ready = 1'b1; j_bus.imem_rdata = 32'h0800_0040;
        m_pc = 32'h0; m_ir = 32'h0; m_cnt = 16'h0;
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_cnt", 32'(retire_count), 32'd0);
        chk("rst_pc_masked", j_pc, 32'h4000_0010);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr0", w_bus.imem_addr, 32'hFFFF_FFFC);
        chk("jmp_addr0", j_bus.imem_addr, 32'h4000_0010);
        @(negedge clk);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("jmp_instr", j_instr, 32'h0800_0040);
        chk("jmp_opcode", 32'(j_opcode), 32'd2);
        chk("jmp_funct", 32'(j_funct), 32'd0);
        @(negedge clk);
        chk("wrap_addr1", w_bus.imem_addr, 32'h0);
        chk("wrap_cnt", 32'(w_cnt), 32'd1);
        chk("jmp_priority", j_bus.imem_addr, 32'h4000_0100);
        chk("jmp_cnt", 32'(j_cnt), 32'd1);
        chk("jmp_pc4", j_pc4, 32'h4000_0104);

        // Sequential zero-wait fetch.
        for (int i = 0; i < 3; i++) do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0, 1'($urandom));
        chk("seq_cnt", 32'(retire_count), 32'd3);
        chk("seq_addr", bus.imem_addr, 32'hC);

        // Branch decisions around pc 0x100.
        do_instr(0, 0, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("jump_to_100", pc, 32'h100);
        do_instr(0, 0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("beq_taken", pc, 32'h0FC);
        do_instr(0, 0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr(0, 0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_not_taken", pc, 32'h104);
        do_instr(0, 0, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b1);
        do_instr(0, 0, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bne_taken", pc, 32'h0FC);

        // Wait states then stall.
        do_instr(3, 2, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait_stall_pc", pc, 32'h100);

        // Reset while a response arrives in FETCH.
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("midrst_req", 32'(bus.imem_req), 32'd0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_cnt", 32'(retire_count), 32'd0);
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        m_pc = 32'h0; m_ir = 32'h0; m_cnt = 16'h0;
        chk("midrst_rereq", 32'(bus.imem_req), 32'd1);

        for (int i = 0; i < 40; i++) begin
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                     1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end
        fetch_chk("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
